// File: rtl/smg_disp_arbiter.sv
// smg_disp_arbiter
//   Round-robin arbiter that shares one 6-digit 7-segment display between
//   three requesters. Each requester offers a 24-bit BCD frame over a
//   valid/ready handshake. Each accepted frame is held on number_sig for at
//   least max(HOLD_MS,1) milliseconds before the next grant.
// Ports
//   clk        : system clock, posedge
//   rst        : asynchronous reset, active-high
//   req_valid  : per-requester frame valid (bit i = requester i)
//   req_data0/1/2 : requester BCD frames, [23:20] = leftmost digit
//   req_ready  : one-hot accept pulse, high only in the GRANT cycle
//   number_sig : frame currently displayed (to scan/decode Number_Sig)
//   cur_owner  : requester index owning number_sig
//   busy       : high whenever the arbiter is not idle
//   bcd_err    : sticky, a captured frame contained a nibble > 9
module smg_disp_arbiter #(
    parameter logic [15:0] T1MS    = 16'd50000,
    parameter logic [15:0] HOLD_MS = 16'd500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data0,
    input  logic [23:0] req_data1,
    input  logic [23:0] req_data2,
    output logic [2:0]  req_ready,
    output logic [23:0] number_sig,
    output logic [1:0]  cur_owner,
    output logic        busy,
    output logic        bcd_err
);

    // HOLD_MS of zero still gives a one-millisecond hold.
    localparam logic [15:0] HOLD_EFF = (HOLD_MS == 16'd0) ? 16'd1 : HOLD_MS;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [1:0]       gnt, gnt_nxt;
    logic [1:0]       last_owner;
    logic [15:0]      pre_cnt, ms_cnt;
    logic [2:0][23:0] data_arr;
    logic [1:0]       c1, c2, c3;
    logic             xfer, pre_wrap, hold_done, frame_bad;

    assign data_arr = {req_data2, req_data1, req_data0};

    function automatic logic [1:0] nxt_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Rotation order starting just after the last owner.
    assign c1 = nxt_idx(last_owner);
    assign c2 = nxt_idx(c1);
    assign c3 = nxt_idx(c2);

    assign xfer      = (state == GRANT) && req_valid[gnt];
    assign pre_wrap  = (pre_cnt == T1MS - 16'd1);
    assign hold_done = pre_wrap && (ms_cnt == HOLD_EFF - 16'd1);
    assign busy      = (state != IDLE);

    always_comb begin
        frame_bad = 1'b0;
        for (int k = 0; k < 6; k++)
            if (data_arr[gnt][4*k +: 4] > 4'd9) frame_bad = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        req_ready = 3'b000;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    if (req_valid[c1])      gnt_nxt = c1;
                    else if (req_valid[c2]) gnt_nxt = c2;
                    else                    gnt_nxt = c3;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                req_ready = 3'b001 << gnt;
                // A withdrawn request forfeits the grant without a transfer.
                state_nxt = req_valid[gnt] ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 2'd0;
            last_owner <= 2'd2;
            number_sig <= 24'h000000;
            cur_owner  <= 2'd0;
            bcd_err    <= 1'b0;
            pre_cnt    <= 16'd0;
            ms_cnt     <= 16'd0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            if (xfer) begin
                number_sig <= data_arr[gnt];
                cur_owner  <= gnt;
                last_owner <= gnt;
                if (frame_bad) bcd_err <= 1'b1;
            end
            // Prescaler and ms counter only run in HOLD; cleared on exit.
            if (state == HOLD && !hold_done) begin
                if (pre_wrap) begin
                    pre_cnt <= 16'd0;
                    ms_cnt  <= ms_cnt + 16'd1;
                end else begin
                    pre_cnt <= pre_cnt + 16'd1;
                end
            end else begin
                pre_cnt <= 16'd0;
                ms_cnt  <= 16'd0;
            end
        end
    end

endmodule
